// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha stream controller.
// Holds the FSM state encoding and the counter-word byte helper.
package chacha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CTR,
        WAIT_BLK,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [5:0] CTR_ADDR    = 6'd48;
    localparam int         BLOCK_BYTES = 64;
    localparam int         CTR_BYTES   = 4;

    // Byte k of the block counter, little-endian as the core stores it.
    function automatic logic [7:0] ctr_byte(input logic [31:0] ctr, input logic [1:0] k);
        logic [31:0] sh;
        sh = ctr >> {k, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/chacha_out_reg.sv
// One-entry valid/ready holding register.
// Latency 1 cycle; accepts a new entry in the same cycle the held one is taken.
module chacha_out_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_vld,
    input  logic [W-1:0] load_dat,
    output logic         load_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    assign load_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load_vld && load_rdy) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_stream.sv
// ChaCha keystream XOR controller: loads the block counter, waits for the core, XORs 64 bytes per block.
// Latency 1 cycle input to output; in_ready drops when the output register is full and not being taken.
module chacha_stream
    import chacha_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ready,
    input  logic        start,
    input  logic [31:0] ctr_init,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        ctr_wrap,
    output logic        blk_write,
    output logic [5:0]  blk_addr,
    output logic [7:0]  blk_wdata,
    input  logic [7:0]  blk_rdata,
    input  logic        blk_ready
);

    state_t      state;
    logic [31:0] ctr;
    logic [5:0]  idx;
    logic        stream_vld;
    logic        stream_rdy;
    logic        fire;
    logic        last_blk_byte;

    assign cfg_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign stream_vld    = in_valid && (state == STREAM);
    assign in_ready      = (state == STREAM) && stream_rdy;
    assign fire          = in_valid && in_ready;
    assign last_blk_byte = (idx == 6'(BLOCK_BYTES - 1));

    chacha_out_reg #(.W(9)) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (stream_vld),
        .load_dat ({in_last, in_data ^ blk_rdata}),
        .load_rdy (stream_rdy),
        .out_vld  (out_valid),
        .out_dat  ({out_last, out_data}),
        .out_rdy  (out_ready)
    );

    // The core address doubles as the keystream read index while streaming.
    always_comb begin
        blk_write = 1'b0;
        blk_addr  = idx;
        blk_wdata = 8'h00;
        case (state)
            IDLE: begin
                blk_write = cfg_we;
                blk_addr  = cfg_addr;
                blk_wdata = cfg_data;
            end
            LOAD_CTR: begin
                blk_write = 1'b1;
                blk_addr  = CTR_ADDR + {4'b0000, idx[1:0]};
                blk_wdata = ctr_byte(ctr, idx[1:0]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctr      <= '0;
            idx      <= '0;
            ctr_wrap <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ctr      <= ctr_init;
                        ctr_wrap <= 1'b0;
                        idx      <= '0;
                        state    <= LOAD_CTR;
                    end
                end
                LOAD_CTR: begin
                    idx <= idx + 6'd1;
                    if (idx[1:0] == 2'(CTR_BYTES - 1)) begin
                        idx   <= '0;
                        state <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (blk_ready) begin
                        idx   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        idx <= idx + 6'd1;
                        if (in_last) begin
                            state <= DRAIN;
                        end else if (last_blk_byte) begin
                            // Refuse to wrap the counter: reusing keystream would break the cipher.
                            if (ctr == 32'hFFFF_FFFF) begin
                                ctr_wrap <= 1'b1;
                                state    <= DRAIN;
                            end else begin
                                ctr   <= ctr + 32'd1;
                                idx   <= '0;
                                state <= LOAD_CTR;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
